teller_dispatcher: RTL
======================

# teller_dispatcher

Teller-side controller of the bank queue system and the consuming end of the queue counter's sensor interface. Each teller window raises a "next customer" request. The block arbitrates round-robin among the active tellers and removes one customer from the queue by pulsing `downSignal`, the front-sensor input of the queue unit. It then confirms that `Pcount` decremented and announces which window the customer must go to.

## Interface
Parameters:
- `TIMEOUT`, default 4: cycles allowed in WAIT for `Pcount` to decrement.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-high.
- `tellerReq`  in  3: per-teller request level, bit i = window i+1; only rising edges count.
- `Tcount`  in  2: number of active tellers (1–3); window i+1 is enabled iff i < Tcount.
- `Pcount`  in  3: people in the queue, driven by the queue unit.
- `emptyFlag`  in  1: queue empty, driven by the queue unit.
- `downSignal`  out  1: one-cycle front-sensor pulse that dequeues one customer.
- `callValid`  out  1: one-cycle strobe; `callWindow` is valid.
- `callWindow`  out  2: window being called (1–3); 0 when no call is in progress.
- `pending`  out  3: latched outstanding requests.
- `servedCount`  out  8: total customers dispatched; wraps 255→0.
- `syncErr`  out  1: sticky; set when the queue count failed to decrement.

## Operation
- Edge detect: `pending[i]` sets on a sampled rising edge of `tellerReq[i]` (0 at the previous edge, 1 now) when window i+1 is enabled.
- Clear: `pending[i]` clears at the end of ANNOUNCE for the granted window. A new rising edge in that same cycle wins and the bit stays set.
- Disabled windows (i ≥ Tcount): the `pending` bit is forced to 0 every cycle. `Tcount`=0 disables all windows and blocks dispatch.
- Round-robin: pointer `rr` in 0..2, reset value 0. Search order starts at `rr`, wrapping 0→1→2→0. After a grant to i, `rr` becomes (i+1) mod 3.
- States:
  - IDLE: if `pending` is nonzero and `emptyFlag`=0, latch grant index g and `prevCount` = `Pcount`, then go to PULSE. Otherwise stay in IDLE.
  - PULSE: `downSignal`=1 for exactly this cycle, then go to WAIT with timer=0.
  - WAIT: if `Pcount` == `prevCount` − 1 (3-bit), go to ANNOUNCE. Otherwise increment the timer; when the timer reaches TIMEOUT, set `syncErr`, keep `pending[g]`, and return to IDLE with no announce.
  - ANNOUNCE: `callValid`=1 and `callWindow`=g+1 for this cycle only. Clear `pending[g]`, increment `servedCount` (mod 256), advance `rr`, then go to IDLE.
- `emptyFlag` rising after IDLE has been left does not abort the cycle. The WAIT check alone decides the outcome.
- `Tcount` changing mid-cycle does not abort the in-flight grant. It only masks `pending` bits.
- `syncErr` clears only on reset.

## Timing
- Reset values: state=IDLE, `downSignal`=0, `callValid`=0, `callWindow`=0, `pending`=0, `servedCount`=0, `syncErr`=0, `rr`=0, edge-detect history=0.
- Assertion of `reset` at any point, including mid-PULSE or WAIT, drops `downSignal` and `callValid` immediately. No pulse is issued after release.
- Request edge sampled at clock edge k with the FSM in IDLE and the queue nonempty:
  - `pending` is set after edge k.
  - IDLE is left at edge k+1.
  - `downSignal` is high between edges k+1 and k+2.
- Best case: `Pcount` decrements by edge k+3 and `callValid` is high between edges k+3 and k+4.
- Back-to-back dispatches are separated by at least one IDLE cycle. `downSignal` is never high on two consecutive cycles.
- All outputs are registered.

## Test plan
- Reset and single dispatch: Tcount=3, Pcount=3, pulse `tellerReq`=001. Required: one `downSignal` pulse; the bench drops Pcount to 2; `callValid` pulses once with `callWindow`=1; `servedCount`=1; `pending`=000.
- Round-robin: Pcount=5, all three requests rise together. Required: grants in order window 1, 2, 3; three pulses; Pcount ends at 2; `servedCount`=3.
- Empty queue: Pcount=0, `emptyFlag`=1, request window 2. Required: no `downSignal`, `pending`=010. After the bench enqueues (Pcount=1, `emptyFlag`=0), window 2 is called.
- Disabled teller: Tcount=1, request on window 3. Required: `pending`[2] stays 0 and no pulse. Tcount=0 with requests gives no pulse.
- Timeout: the bench holds Pcount at 4 after the pulse. Required: after 4 WAIT cycles `syncErr`=1, no `callValid`, `pending` bit retained, and a re-dispatch follows.
- Reset mid-WAIT: assert `reset` during WAIT. Required: all outputs 0 immediately; after release, no stale `callValid` or `downSignal`.

Source files
------------

// File: rtl/teller_dispatcher.sv
// teller_dispatcher: round-robin teller arbitration for the bank queue.
// Dequeues one customer with a downSignal pulse, confirms that Pcount
// dropped by one, then announces the window the customer should go to.
module teller_dispatcher #(
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tellerReq,
    input  logic [1:0] Tcount,
    input  logic [2:0] Pcount,
    input  logic       emptyFlag,
    output logic       downSignal,
    output logic       callValid,
    output logic [1:0] callWindow,
    output logic [2:0] pending,
    output logic [7:0] servedCount,
    output logic       syncErr
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_ANNOUNCE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      req_hist_q, req_hist_d;
    logic [2:0]      pending_q, pending_d;
    logic [1:0]      rr_q, rr_d;
    logic [1:0]      grant_q, grant_d;
    logic [2:0]      prev_count_q, prev_count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            down_signal_q, down_signal_d;
    logic            call_valid_q, call_valid_d;
    logic [1:0]      call_window_q, call_window_d;
    logic [7:0]      served_count_q, served_count_d;
    logic            sync_err_q, sync_err_d;

    logic [2:0]      en_mask;
    logic [2:0]      req_rise;
    logic [2:0]      clr_mask;
    logic [1:0]      rr_pick;
    logic [1:0]      idx1;
    logic [1:0]      idx2;
    logic [TW-1:0]   timer_inc;

    // Window i+1 is enabled iff i < Tcount.
    assign en_mask   = {Tcount == 2'd3, Tcount >= 2'd2, Tcount >= 2'd1};
    assign req_rise  = tellerReq & ~req_hist_q & en_mask;
    assign timer_inc = timer_q + 1'b1;

    // Round-robin pick: first pending window starting at rr, wrapping 2->0.
    always_comb begin
        idx1    = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        idx2    = (idx1 == 2'd2) ? 2'd0 : idx1 + 2'd1;
        rr_pick = idx2;
        if (pending_q[idx1]) rr_pick = idx1;
        if (pending_q[rr_q]) rr_pick = rr_q;
    end

    // Next-state and registered-output logic for the dispatch FSM.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        prev_count_d   = prev_count_q;
        timer_d        = timer_q;
        rr_d           = rr_q;
        served_count_d = served_count_q;
        sync_err_d     = sync_err_q;
        clr_mask       = 3'b000;
        down_signal_d  = 1'b0;
        call_valid_d   = 1'b0;
        call_window_d  = 2'd0;
        req_hist_d     = tellerReq;

        case (state_q)
            S_IDLE: begin
                if ((|pending_q) && !emptyFlag) begin
                    grant_d       = rr_pick;
                    prev_count_d  = Pcount;
                    down_signal_d = 1'b1;
                    state_d       = S_PULSE;
                end
            end
            S_PULSE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Pcount == prev_count_q - 3'd1) begin
                    call_valid_d  = 1'b1;
                    call_window_d = grant_q + 2'd1;
                    state_d       = S_ANNOUNCE;
                end else begin
                    timer_d = timer_inc;
                    // Queue never confirmed the dequeue: flag it, keep the
                    // request pending so it is retried from IDLE.
                    if (timer_inc == TW'(TIMEOUT)) begin
                        sync_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_ANNOUNCE: begin
                clr_mask[grant_q] = 1'b1;
                served_count_d    = served_count_q + 8'd1;
                rr_d              = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh rising edge in the clear cycle wins over the clear.
        pending_d = ((pending_q & ~clr_mask) | req_rise) & en_mask;
    end

    // State and output registers, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            req_hist_q     <= 3'b000;
            pending_q      <= 3'b000;
            rr_q           <= 2'd0;
            grant_q        <= 2'd0;
            prev_count_q   <= 3'd0;
            timer_q        <= '0;
            down_signal_q  <= 1'b0;
            call_valid_q   <= 1'b0;
            call_window_q  <= 2'd0;
            served_count_q <= 8'd0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_hist_q     <= req_hist_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            grant_q        <= grant_d;
            prev_count_q   <= prev_count_d;
            timer_q        <= timer_d;
            down_signal_q  <= down_signal_d;
            call_valid_q   <= call_valid_d;
            call_window_q  <= call_window_d;
            served_count_q <= served_count_d;
            sync_err_q     <= sync_err_d;
        end
    end

    assign downSignal  = down_signal_q;
    assign callValid   = call_valid_q;
    assign callWindow  = call_window_q;
    assign pending     = pending_q;
    assign servedCount = served_count_q;
    assign syncErr     = sync_err_q;

endmodule
